// File: rtl/lane_timer_bank.sv
// lane_timer_bank: a bank of independent timer channels driven by one shared
// prescaler. Each channel counts prescaled ticks up to its own limit and then
// either reloads (periodic) or latches a done flag (one-shot).

module lane_timer_bank #(
  parameter int NUM_CH   = 7,
  parameter int CNT_W    = 16,
  parameter int PRESCALE = 1
) (
  input  logic                    clk_b,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH-1:0]       ch_restart,
  input  logic [NUM_CH-1:0]       ch_periodic,
  input  logic [NUM_CH*CNT_W-1:0] ch_limit,
  output logic [NUM_CH-1:0]       ch_done,
  output logic [NUM_CH-1:0]       ch_pulse,
  output logic [NUM_CH*CNT_W-1:0] ch_count
);

  // A one-bit prescaler is kept even when PRESCALE is 1 so the width is never
  // zero; it then simply sits at 0 and the tick is asserted every cycle.
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  logic [PS_W-1:0] prescaler;
  logic            tick;

  // Free-running prescaler shared by every channel, wrapping at PRESCALE-1.
  always_ff @(posedge clk_b) begin
    if (rst) begin
      prescaler <= '0;
    end else if (prescaler == PS_LAST) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + PS_W'(1);
    end
  end

  assign tick = (prescaler == PS_LAST);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t           state;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] limit;
    logic [CNT_W:0]   count_inc;
    logic             done;
    logic             pulse;

    // The increment carries an extra bit so the expiry compare cannot be
    // fooled by wrap-around, even if the limit was lowered below the count.
    assign limit     = ch_limit[i*CNT_W +: CNT_W];
    assign count_inc = {1'b0, count} + {{CNT_W{1'b0}}, 1'b1};

    // Per-channel state machine: reset, disable and restart take priority
    // over tick processing; a limit of zero freezes the channel where it is.
    always_ff @(posedge clk_b) begin
      if (rst) begin
        state <= IDLE;
        count <= '0;
        done  <= 1'b0;
        pulse <= 1'b0;
      end else if (!ch_en[i]) begin
        state <= IDLE;
        count <= '0;
        done  <= 1'b0;
        pulse <= 1'b0;
      end else if (ch_restart[i]) begin
        state <= RUN;
        count <= '0;
        done  <= 1'b0;
        pulse <= 1'b0;
      end else begin
        pulse <= 1'b0;
        case (state)
          IDLE: begin
            state <= RUN;
            count <= '0;
            done  <= 1'b0;
          end
          RUN: begin
            if (tick && (limit != '0)) begin
              if (count_inc >= {1'b0, limit}) begin
                pulse <= 1'b1;
                if (ch_periodic[i]) begin
                  count <= '0;
                end else begin
                  count <= limit;
                  done  <= 1'b1;
                  state <= DONE;
                end
              end else begin
                count <= count_inc[CNT_W-1:0];
              end
            end
          end
          DONE: begin
            state <= DONE;
          end
          default: begin
            state <= IDLE;
            count <= '0;
            done  <= 1'b0;
          end
        endcase
      end
    end

    assign ch_count[i*CNT_W +: CNT_W] = count;
    assign ch_done[i]                 = done;
    assign ch_pulse[i]                = pulse;
  end

endmodule
